scan_chain_driver: RTL and testbench
====================================

Name: scan_chain_driver

Overview:
- Hardware master for the cnn_top two-phase scan chain. It replaces bench-driven phi/phib/scan_i0o1/load sequencing so an FPGA or on-board controller can configure and read the chip.
- Shift-in mode serialises a parallel IN_LEN-bit configuration word MSB-first and then pulses load.
- Capture mode pulses scan_i0o1, then shifts OUT_LEN result bits back into a parallel word.
- Sits directly upstream of cnn_top's scan port; its outputs wire to phi/phib/scan_i0o1/load/scan_in, and cnn_top scan_out returns to it.

Parameters:
- IN_LEN, 188, scan-in chain length in bits.
- OUT_LEN, 50, scan-out chain length in bits.
- PH_CYC, 1, clk_signal_ext cycles per sequencing step (≥1); sets scan speed.

Ports:
- clk_signal_ext  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_in  input  1  pulse: begin a shift-in of din.
- din  input  IN_LEN  word to scan in; din[IN_LEN-1] is shifted first.
- start_out  input  1  pulse: begin capture plus shift-out.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- dout  output  OUT_LEN  captured result; dout[OUT_LEN-1] is the first bit received.
- phi  output  1  scan clock, phase I.
- phib  output  1  scan clock, phase II.
- scan_i0o1  output  1  chip mode: 0 = in, 1 = capture.
- load  output  1  chip load strobe.
- scan_in  output  1  serial data to chip.
- scan_out  input  1  serial data from chip.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - busy, done, phi, phib, scan_i0o1, load, scan_in and dout all go to 0.
  - FSM returns to IDLE, step timer and bit counter clear, no done pulse is issued.
- All outputs are registered. phi and phib are never high simultaneously; every transition is separated by at least one full step.
- Step timing: each FSM step lasts exactly PH_CYC cycles, counted by a step timer.
- IDLE start handling:
  - start_in=1 → latch din into the shift register and set busy the next cycle.
  - start_out=1 → set busy the next cycle.
  - If both are high together, start_in wins and start_out is dropped. Starts are not queued.
  - Starts while busy=1 are ignored.
- Shift-in per bit, five steps:
  - S0: scan_in = shreg MSB, phi = phib = 0.
  - S1: phi = 1.
  - S2: phi = 0.
  - S3: phib = 1.
  - S4: phib = 0, then shreg shifts left by 1.
  - Repeat for IN_LEN bits. scan_in stays stable from S0 through S4.
- After the last bit: step LD_H (load = 1), then step LD_L (load = 0).
  - At the end of LD_L, done pulses for 1 cycle and busy falls in the same cycle.
  - scan_in holds its last value until the next operation.
- Shift-in duration: busy high for exactly IN_LEN·5·PH_CYC + 2·PH_CYC cycles.
- Capture sequence, six steps:
  - C0: scan_i0o1 = 1.
  - C1: phi = 1.
  - C2: phi = 0.
  - C3: phib = 1.
  - C4: phib = 0.
  - C5: scan_i0o1 = 0.
- Shift-out per bit, five steps S0..S4 with the same phi/phib pattern as shift-in; scan_in is held at 0.
  - scan_out is sampled on the last cycle of S0, before phi rises.
  - The sample shifts into the LSB of the capture register.
  - After OUT_LEN bits, the capture register copies to dout in the same cycle as the done pulse.
  - dout only changes at done.
- Capture duration: busy high for exactly 6·PH_CYC + OUT_LEN·5·PH_CYC cycles.
- Counters:
  - Bit counter wide enough for max(IN_LEN, OUT_LEN).
  - Step timer counts 0..PH_CYC-1 and wraps to 0 at each step change.
- FSM states: IDLE, SI_BIT(S0–S4), SI_LD_H, SI_LD_L, CAP(C0–C5), SO_BIT(S0–S4), FIN. FIN issues done and returns to IDLE.

Test Plan:
- Reset defaults: assert rst mid-clock, hold 3 cycles → all outputs 0 asynchronously, busy 0; release with no start → outputs stay 0 for 100 cycles.
- Shift-in, PH_CYC=1, din = 188'h…A5 (pattern 1010_0101 in the LSBs):
  - busy high for exactly 942 cycles.
  - Chip-side model reconstructs din bit-exact from scan_in at phi rising edges.
  - load high for 1 cycle after the 188th phib fall; a single done pulse follows.
- Capture, PH_CYC=2, chip model returns scan_out pattern 50'h2_AAAA_5555_0F0F:
  - busy high for exactly 512 cycles.
  - scan_i0o1 high for 10 cycles spanning exactly one phi and one phib pulse.
  - dout = 50'h2_AAAA_5555_0F0F at done.
- Start arbitration: start_in and start_out high in the same IDLE cycle → shift-in runs; no capture follows. start_out pulsed at cycle 100 of the shift-in → ignored, done count = 1.
- Abort: assert rst at bit 90 of a shift-in → phi, phib and load drop to 0 immediately, no done; a new start_in after release completes normally in 942 cycles.
- Non-overlap checker across both modes: phi & phib never both 1; load and scan_i0o1 never both 1.

Source files
------------

// File: rtl/scan_chain_driver.sv
// rtl/scan_chain_driver.sv - two-phase scan chain master: serial shift-in with load, capture with shift-out
module scan_chain_driver #(
    parameter int IN_LEN  = 188,
    parameter int OUT_LEN = 50,
    parameter int PH_CYC  = 1
) (
    input  logic               clk_signal_ext,
    input  logic               rst,
    input  logic               start_in,
    input  logic [IN_LEN-1:0]  din,
    input  logic               start_out,
    output logic               busy,
    output logic               done,
    output logic [OUT_LEN-1:0] dout,
    output logic               phi,
    output logic               phib,
    output logic               scan_i0o1,
    output logic               load,
    output logic               scan_in,
    input  logic               scan_out
);

    localparam int MAXL = (IN_LEN > OUT_LEN) ? IN_LEN : OUT_LEN;
    localparam int BW   = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam int TW   = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;
    localparam logic [BW-1:0] IN_LAST  = BW'(IN_LEN - 1);
    localparam logic [BW-1:0] OUT_LAST = BW'(OUT_LEN - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(PH_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, SI_BIT, SI_LD_H, SI_LD_L, CAP, SO_BIT, FIN
    } state_t;

    state_t             r_state;
    logic [2:0]         r_step;
    logic [TW-1:0]      r_timer;
    logic [BW-1:0]      r_bit;
    logic [IN_LEN-1:0]  r_shreg;
    logic [OUT_LEN-1:0] r_cap;
    logic [OUT_LEN-1:0] r_dout;
    logic               r_busy, r_done, r_phi, r_phib, r_sio, r_load, r_scan_in;
    logic               w_step_end;

    assign w_step_end = (r_timer == T_LAST);

    assign busy      = r_busy;
    assign done      = r_done;
    assign dout      = r_dout;
    assign phi       = r_phi;
    assign phib      = r_phib;
    assign scan_i0o1 = r_sio;
    assign load      = r_load;
    assign scan_in   = r_scan_in;

    // Sequencer: each step lasts PH_CYC cycles; outputs for a step are registered on entry to it
    always_ff @(posedge clk_signal_ext or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_step    <= 3'd0;
            r_timer   <= '0;
            r_bit     <= '0;
            r_shreg   <= '0;
            r_cap     <= '0;
            r_dout    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_phi     <= 1'b0;
            r_phib    <= 1'b0;
            r_sio     <= 1'b0;
            r_load    <= 1'b0;
            r_scan_in <= 1'b0;
        end else begin
            if (r_state == IDLE || r_state == FIN || w_step_end)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;

            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_shreg   <= din;
                        r_scan_in <= din[IN_LEN-1];
                        r_state   <= SI_BIT;
                        r_step    <= 3'd0;
                        r_bit     <= '0;
                        r_busy    <= 1'b1;
                    end else if (start_out) begin
                        r_scan_in <= 1'b0;
                        r_sio     <= 1'b1;
                        r_state   <= CAP;
                        r_step    <= 3'd0;
                        r_bit     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                SI_BIT, SO_BIT: begin
                    if (w_step_end) begin
                        case (r_step)
                            3'd0: begin
                                // chip data is settled by the end of S0, just before phi rises
                                if (r_state == SO_BIT)
                                    r_cap <= {r_cap[OUT_LEN-2:0], scan_out};
                                r_phi  <= 1'b1;
                                r_step <= 3'd1;
                            end
                            3'd1: begin
                                r_phi  <= 1'b0;
                                r_step <= 3'd2;
                            end
                            3'd2: begin
                                r_phib <= 1'b1;
                                r_step <= 3'd3;
                            end
                            3'd3: begin
                                r_phib <= 1'b0;
                                r_step <= 3'd4;
                            end
                            default: begin
                                if (r_state == SI_BIT) begin
                                    r_shreg <= r_shreg << 1;
                                    if (r_bit == IN_LAST) begin
                                        r_load  <= 1'b1;
                                        r_state <= SI_LD_H;
                                    end else begin
                                        r_scan_in <= r_shreg[IN_LEN-2];
                                        r_bit     <= r_bit + 1'b1;
                                        r_step    <= 3'd0;
                                    end
                                end else begin
                                    if (r_bit == OUT_LAST) begin
                                        r_dout  <= r_cap;
                                        r_done  <= 1'b1;
                                        r_busy  <= 1'b0;
                                        r_state <= FIN;
                                    end else begin
                                        r_bit  <= r_bit + 1'b1;
                                        r_step <= 3'd0;
                                    end
                                end
                            end
                        endcase
                    end
                end
                SI_LD_H: begin
                    if (w_step_end) begin
                        r_load  <= 1'b0;
                        r_state <= SI_LD_L;
                    end
                end
                SI_LD_L: begin
                    if (w_step_end) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end
                end
                CAP: begin
                    if (w_step_end) begin
                        case (r_step)
                            3'd0: begin r_phi  <= 1'b1; r_step <= 3'd1; end
                            3'd1: begin r_phi  <= 1'b0; r_step <= 3'd2; end
                            3'd2: begin r_phib <= 1'b1; r_step <= 3'd3; end
                            3'd3: begin r_phib <= 1'b0; r_step <= 3'd4; end
                            3'd4: begin r_sio  <= 1'b0; r_step <= 3'd5; end
                            default: begin
                                r_state <= SO_BIT;
                                r_step  <= 3'd0;
                                r_bit   <= '0;
                            end
                        endcase
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_driver.sv
// tb/tb_scan_chain_driver.sv - self-checking bench for scan_chain_driver with a chip-side scan model
module tb_scan_chain_driver;

    localparam int IN_LEN  = 188;
    localparam int OUT_LEN = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [IN_LEN-1:0]  din;
    logic               start_in[2], start_out[2];
    logic               busy[2], done[2], phi[2], phib[2], sio[2], load[2], scan_in[2], scan_out[2];
    logic [OUT_LEN-1:0] dout[2];
    logic [OUT_LEN-1:0] cap_pat[2];

    scan_chain_driver #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .PH_CYC(1)) u_dut0 (
        .clk_signal_ext(clk), .rst(rst), .start_in(start_in[0]), .din(din),
        .start_out(start_out[0]), .busy(busy[0]), .done(done[0]), .dout(dout[0]),
        .phi(phi[0]), .phib(phib[0]), .scan_i0o1(sio[0]), .load(load[0]),
        .scan_in(scan_in[0]), .scan_out(scan_out[0])
    );

    scan_chain_driver #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .PH_CYC(2)) u_dut1 (
        .clk_signal_ext(clk), .rst(rst), .start_in(start_in[1]), .din(din),
        .start_out(start_out[1]), .busy(busy[1]), .done(done[1]), .dout(dout[1]),
        .phi(phi[1]), .phib(phib[1]), .scan_i0o1(sio[1]), .load(load[1]),
        .scan_in(scan_in[1]), .scan_out(scan_out[1])
    );

    int busy_cnt[2]  = '{0, 0};
    int done_cnt[2]  = '{0, 0};
    int load_cnt[2]  = '{0, 0};
    int sio_cnt[2]   = '{0, 0};
    int sio_phi[2]   = '{0, 0};
    int sio_phib[2]  = '{0, 0};
    int phi_rise[2]  = '{0, 0};
    int phib_fall[2] = '{0, 0};
    int load_mark[2] = '{0, 0};
    int viol[2]      = '{0, 0};
    logic prev_phi[2]  = '{1'b0, 1'b0};
    logic prev_phib[2] = '{1'b0, 1'b0};
    logic prev_load[2] = '{1'b0, 1'b0};
    logic [IN_LEN-1:0]  chip_in[2]  = '{default: '0};
    logic [OUT_LEN-1:0] chip_out[2] = '{default: '0};

    assign scan_out[0] = chip_out[0][OUT_LEN-1];
    assign scan_out[1] = chip_out[1][OUT_LEN-1];

    // Chip model and activity counters, sampled on the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (busy[k] === 1'b1) busy_cnt[k] <= busy_cnt[k] + 1;
            if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
            if (load[k] === 1'b1) load_cnt[k] <= load_cnt[k] + 1;
            if (sio[k]  === 1'b1) sio_cnt[k]  <= sio_cnt[k] + 1;
            if ((phi[k] === 1'b1 && phib[k] === 1'b1) || (load[k] === 1'b1 && sio[k] === 1'b1))
                viol[k] <= viol[k] + 1;
            if (phi[k] === 1'b1 && prev_phi[k] === 1'b0) begin
                phi_rise[k] <= phi_rise[k] + 1;
                if (sio[k]) begin
                    sio_phi[k]  <= sio_phi[k] + 1;
                    chip_out[k] <= cap_pat[k];
                end else begin
                    chip_in[k] <= {chip_in[k][IN_LEN-2:0], scan_in[k]};
                end
            end
            if (phib[k] === 1'b1 && prev_phib[k] === 1'b0) begin
                if (sio[k]) sio_phib[k] <= sio_phib[k] + 1;
                else        chip_out[k] <= chip_out[k] << 1;
            end
            if (phib[k] === 1'b0 && prev_phib[k] === 1'b1) phib_fall[k] <= phib_fall[k] + 1;
            if (load[k] === 1'b1 && prev_load[k] === 1'b0) load_mark[k] <= phib_fall[k];
            prev_phi[k]  <= phi[k];
            prev_phib[k] <= phib[k];
            prev_load[k] <= load[k];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic start_op(input int k, input int op);
        @(negedge clk);
        if (op == 0 || op == 2) start_in[k] = 1'b1;
        if (op == 1 || op == 2) start_out[k] = 1'b1;
        @(negedge clk);
        start_in[k]  = 1'b0;
        start_out[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input string name);
        int n;
        n = 0;
        while (busy[k] === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {255'd0, busy[k]}, 256'd0);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        int                 k;
        int                 op;
        logic [IN_LEN-1:0]  din;
        logic [OUT_LEN-1:0] pat;
        int                 exp_busy;
        int                 exp_sio;
        int                 exp_pulses;
        logic [OUT_LEN-1:0] exp_dout;
    } vec_t;

    localparam logic [OUT_LEN-1:0] P1 = 50'h2_AAAA_5555_0F0F;
    localparam logic [OUT_LEN-1:0] P2 = 50'h1_2345_6789_ABCD;
    localparam logic [IN_LEN-1:0]  D1 = {60'h0123_4567_89AB_CDE, 64'hFEDC_BA98_7654_3210,
                                         56'h1122_3344_5566_77, 8'hA5};
    localparam logic [IN_LEN-1:0]  D2 = {60'hF0F0_F0F0_F0F0_F0F, 64'h0000_FFFF_0000_FFFF,
                                         56'h5A5A_5A5A_5A5A_5A, 8'h3C};

    vec_t vecs[6];

    initial begin
        int b0, d0, l0, s0, sp0, sb0, pf0, pr0, n, bad;
        logic [IN_LEN-1:0] ones;
        string nm;

        ones = '1;
        vecs[0] = '{0, 0, D1,     '0, 942, 0,  0, '0};
        vecs[1] = '{0, 1, '0,     P1, 256, 5,  1, P1};
        vecs[2] = '{0, 1, '0,     P2, 256, 5,  1, P2};
        vecs[3] = '{0, 2, ones,   P1, 942, 0,  0, P2};
        vecs[4] = '{0, 0, 188'h1, '0, 942, 0,  0, P2};
        vecs[5] = '{1, 1, '0,     P1, 512, 10, 1, P1};

        rst = 1'b0;
        din = '0;
        for (int k = 0; k < 2; k++) begin
            start_in[k] = 1'b0; start_out[k] = 1'b0; cap_pat[k] = '0;
        end

        // reset asserted between clock edges must clear outputs without a clock edge
        #12 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            nm = $sformatf("rst_async_%0d", k);
            check(nm, {busy[k], done[k], phi[k], phib[k], sio[k], load[k], scan_in[k], dout[k]}, 256'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if ({busy[k], done[k], phi[k], phib[k], sio[k], load[k], scan_in[k], dout[k]} !== '0) bad++;
        end
        check("idle_100", bad, 0);

        for (int i = 0; i < 6; i++) begin
            automatic int k = vecs[i].k;
            din = vecs[i].din;
            cap_pat[k] = vecs[i].pat;
            b0 = busy_cnt[k]; d0 = done_cnt[k]; l0 = load_cnt[k]; s0 = sio_cnt[k];
            sp0 = sio_phi[k]; sb0 = sio_phib[k]; pf0 = phib_fall[k];
            start_op(k, vecs[i].op);
            wait_idle(k, $sformatf("v%0d", i));
            check($sformatf("v%0d_busy", i), busy_cnt[k] - b0, vecs[i].exp_busy);
            check($sformatf("v%0d_done", i), done_cnt[k] - d0, 1);
            check($sformatf("v%0d_dout", i), dout[k], vecs[i].exp_dout);
            check($sformatf("v%0d_sio", i), s0 + vecs[i].exp_sio, sio_cnt[k]);
            check($sformatf("v%0d_sio_phi", i), sio_phi[k] - sp0, vecs[i].exp_pulses);
            check($sformatf("v%0d_sio_phib", i), sio_phib[k] - sb0, vecs[i].exp_pulses);
            if (vecs[i].op != 1) begin
                check($sformatf("v%0d_chip_in", i), chip_in[k], vecs[i].din);
                check($sformatf("v%0d_load", i), load_cnt[k] - l0, 1);
                check($sformatf("v%0d_load_pos", i), load_mark[k] - pf0, 188);
            end else begin
                check($sformatf("v%0d_noload", i), load_cnt[k] - l0, 0);
            end
        end

        // start_out during a shift-in must be ignored
        din = D2;
        b0 = busy_cnt[0]; d0 = done_cnt[0]; s0 = sio_cnt[0];
        start_op(0, 0);
        repeat (98) @(negedge clk);
        start_out[0] = 1'b1;
        @(negedge clk);
        start_out[0] = 1'b0;
        wait_idle(0, "arb");
        check("arb_busy", busy_cnt[0] - b0, 942);
        check("arb_done", done_cnt[0] - d0, 1);
        check("arb_nocap", sio_cnt[0] - s0, 0);
        check("arb_chip_in", chip_in[0], D2);

        // abort mid shift-in
        din = D1;
        d0 = done_cnt[0]; pr0 = phi_rise[0];
        start_op(0, 0);
        n = 0;
        while (phi_rise[0] - pr0 < 91 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", (phi_rise[0] - pr0 >= 91), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_outs", {phi[0], phib[0], load[0], busy[0]}, 256'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_nodone", done_cnt[0] - d0, 0);
        din = D2;
        b0 = busy_cnt[0]; d0 = done_cnt[0];
        start_op(0, 0);
        wait_idle(0, "rerun");
        check("rerun_busy", busy_cnt[0] - b0, 942);
        check("rerun_done", done_cnt[0] - d0, 1);
        check("rerun_chip_in", chip_in[0], D2);

        check("overlap_0", viol[0], 0);
        check("overlap_1", viol[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
